// File: rtl/sa_cache_if.sv
// CPU-side and memory-side signal bundle for sa_cache.
// slave modport is the cache's view; master is the CPU/memory environment's view.
interface sa_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  hit;
    logic                  miss;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;
    logic [31:0]           stat_hits;
    logic [31:0]           stat_misses;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, hit, miss,
        output mem_req, mem_we, mem_addr, mem_wdata, stat_hits, stat_misses
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, hit, miss,
        input  mem_req, mem_we, mem_addr, mem_wdata, stat_hits, stat_misses
    );
endinterface

// File: rtl/sa_cache.sv
// 2-way set-associative, write-through / no-write-allocate word cache with one LRU bit per set.
// Read hits complete in 0 wait states; SA_CACHE_STATS_EN adds read hit/miss counters.
module sa_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    sa_cache_if.slave   bus
);
    localparam int NUM_SETS = 2 ** SET_BITS;
    localparam int WORD_W   = ADDR_WIDTH - 2;
    localparam int TAG_W    = ADDR_WIDTH - SET_BITS - 2;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t                  state_q;
    logic [1:0]              valid_q [NUM_SETS];
    logic [NUM_SETS-1:0]     lru_q;
    logic [TAG_W-1:0]        tag_q   [NUM_SETS][2];
    logic [DATA_WIDTH-1:0]   data_q  [NUM_SETS][2];
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    // In IDLE the live CPU address is looked up; once a transaction is open,
    // the latched memory address is used so CPU changes have no effect.
    logic [WORD_W-1:0]       lk_word;
    logic [SET_BITS-1:0]     idx;
    logic [TAG_W-1:0]        lk_tag;
    logic                    hit0, hit1, any_hit, hit_way, victim;
    logic                    idle_req, rd_hit, fetch_done, write_done;

    assign lk_word = (state_q == IDLE) ? bus.cpu_addr[ADDR_WIDTH-1:2] : mem_addr_q[ADDR_WIDTH-1:2];
    assign idx     = lk_word[SET_BITS-1:0];
    assign lk_tag  = lk_word[WORD_W-1:SET_BITS];

    assign hit0    = valid_q[idx][0] && (tag_q[idx][0] == lk_tag);
    assign hit1    = valid_q[idx][1] && (tag_q[idx][1] == lk_tag);
    assign any_hit = hit0 || hit1;
    assign hit_way = hit0 ? 1'b0 : 1'b1;
    assign victim  = !valid_q[idx][0] ? 1'b0 :
                     !valid_q[idx][1] ? 1'b1 : lru_q[idx];

    assign idle_req   = rst_n && (state_q == IDLE) && bus.cpu_req;
    assign rd_hit     = idle_req && !bus.cpu_we && any_hit;
    assign fetch_done = rst_n && (state_q == FETCH) && bus.mem_ack;
    assign write_done = rst_n && (state_q == WRITE) && bus.mem_ack;

    assign bus.hit       = idle_req && any_hit;
    assign bus.miss      = idle_req && !any_hit;
    assign bus.cpu_ready = rd_hit || fetch_done || write_done;
    assign bus.cpu_rdata = (state_q == FETCH) ? bus.mem_rdata : data_q[idx][hit_way];
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lru_q     <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= 2'b00;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req) begin
                        if (!bus.cpu_we && any_hit) begin
                            lru_q[idx] <= ~hit_way;
                        end else begin
                            state_q     <= bus.cpu_we ? WRITE : FETCH;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.cpu_we;
                            mem_addr_q  <= bus.cpu_addr & ~ADDR_WIDTH'(3);
                            mem_wdata_q <= bus.cpu_wdata;
                        end
                    end
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        valid_q[idx][victim] <= 1'b1;
                        lru_q[idx]           <= ~victim;
                        mem_req_q            <= 1'b0;
                        state_q              <= IDLE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        if (any_hit) begin
                            lru_q[idx] <= ~hit_way;
                        end
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity alone gates their use.
    always_ff @(posedge clk) begin
        if (fetch_done) begin
            tag_q[idx][victim]  <= lk_tag;
            data_q[idx][victim] <= bus.mem_rdata;
        end else if (write_done && any_hit) begin
            data_q[idx][hit_way] <= mem_wdata_q;
        end
    end

`ifdef SA_CACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    assign stat_hits_d   = stat_hits_q + 32'd1;
    assign stat_misses_d = stat_misses_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            if (rd_hit) begin
                stat_hits_q <= stat_hits_d;
            end
            if (fetch_done) begin
                stat_misses_q <= stat_misses_d;
            end
        end
    end

    assign bus.stat_hits   = stat_hits_q;
    assign bus.stat_misses = stat_misses_q;
`else
    assign bus.stat_hits   = 32'd0;
    assign bus.stat_misses = 32'd0;
`endif
endmodule

// File: tb/tb_sa_cache.sv
// Directed bench for sa_cache: miss/fill, hit, LRU eviction, write-through, reset abort, stats.
module tb_sa_cache;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_hits = 0;
    int   exp_misses = 0;
    logic [31:0] want_h, want_m;

    always #5 clk = ~clk;

    sa_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    sa_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SET_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read; on a miss, memory answers 'delay' cycles after mem_req rises.
    // alt_addr is driven onto cpu_addr while the fetch is outstanding.
    task automatic read_op(input logic [31:0] addr, input logic [31:0] alt_addr,
                           input logic [31:0] dat, input logic exp_hit, input int delay);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = addr;
        #1;
        chk($sformatf("rd_%0h_hit", addr),  32'(bus.hit),  32'(exp_hit));
        chk($sformatf("rd_%0h_miss", addr), 32'(bus.miss), 32'(!exp_hit));
        if (exp_hit) begin
            exp_hits++;
            chk($sformatf("rd_%0h_ready", addr), 32'(bus.cpu_ready), 32'd1);
            chk($sformatf("rd_%0h_rdata", addr), bus.cpu_rdata, dat);
        end else begin
            exp_misses++;
            chk($sformatf("rd_%0h_noready", addr), 32'(bus.cpu_ready), 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("rd_%0h_memreq", addr),  32'(bus.mem_req), 32'd1);
            chk($sformatf("rd_%0h_memwe", addr),   32'(bus.mem_we),  32'd0);
            chk($sformatf("rd_%0h_memaddr", addr), bus.mem_addr, addr & ~32'd3);
            chk($sformatf("rd_%0h_fetch_hit", addr), 32'({bus.hit, bus.miss}), 32'd0);
            bus.cpu_addr = alt_addr;
            for (int i = 1; i < delay; i++) begin
                @(negedge clk);
                #1;
                chk($sformatf("rd_%0h_hold", addr), {bus.mem_addr[31:1], bus.mem_req}, (addr & ~32'd3) | 32'd1);
            end
            @(negedge clk);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = dat;
            #1;
            chk($sformatf("rd_%0h_fill_ready", addr), 32'(bus.cpu_ready), 32'd1);
            chk($sformatf("rd_%0h_fill_rdata", addr), bus.cpu_rdata, dat);
        end
        @(negedge clk);
        bus.mem_ack  = 1'b0;
        bus.cpu_req  = 1'b0;
    endtask

    task automatic write_op(input logic [31:0] addr, input logic [31:0] wdat, input logic exp_hit);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdat;
        #1;
        chk($sformatf("wr_%0h_hit", addr),  32'(bus.hit),  32'(exp_hit));
        chk($sformatf("wr_%0h_miss", addr), 32'(bus.miss), 32'(!exp_hit));
        chk($sformatf("wr_%0h_noready", addr), 32'(bus.cpu_ready), 32'd0);
        @(negedge clk);
        #1;
        chk($sformatf("wr_%0h_memreq", addr),   32'(bus.mem_req), 32'd1);
        chk($sformatf("wr_%0h_memwe", addr),    32'(bus.mem_we),  32'd1);
        chk($sformatf("wr_%0h_memaddr", addr),  bus.mem_addr, addr & ~32'd3);
        chk($sformatf("wr_%0h_memwdata", addr), bus.mem_wdata, wdat);
        bus.cpu_addr  = 32'h0000_0FF0;
        bus.cpu_wdata = 32'h5555_AAAA;
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #1;
        chk($sformatf("wr_%0h_ready", addr),     32'(bus.cpu_ready), 32'd1);
        chk($sformatf("wr_%0h_wdata_hold", addr), bus.mem_wdata, wdat);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready",  32'(bus.cpu_ready), 32'd0);
        chk("rst_memreq", 32'(bus.mem_req),   32'd0);
        chk("rst_memwe",  32'(bus.mem_we),    32'd0);
        chk("rst_hitmiss", 32'({bus.hit, bus.miss}), 32'd0);
        chk("rst_shits",  bus.stat_hits,   32'd0);
        chk("rst_smiss",  bus.stat_misses, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Set 0 holds 0x40/0x60/0x80/0x100 (tags 2/3/4/8).
        read_op(32'h40, 32'h40, 32'hDEAD_BEEF, 1'b0, 3);
        read_op(32'h40, 32'h40, 32'hDEAD_BEEF, 1'b1, 0);
        read_op(32'h60, 32'h60, 32'h6060_6060, 1'b0, 2);
        read_op(32'h40, 32'h40, 32'hDEAD_BEEF, 1'b1, 0);
        read_op(32'h80, 32'h80, 32'h8080_8080, 1'b0, 1);   // evicts 0x60
        read_op(32'h60, 32'h60, 32'h6161_6161, 1'b0, 1);   // evicts 0x40
        read_op(32'h80, 32'h80, 32'h8080_8080, 1'b1, 0);
        read_op(32'h40, 32'h40, 32'h4040_4040, 1'b0, 2);   // evicts 0x60
        write_op(32'h40, 32'hCAFE_0001, 1'b1);
        read_op(32'h40, 32'h40, 32'hCAFE_0001, 1'b1, 0);
        write_op(32'h100, 32'h0BAD_F00D, 1'b0);
        read_op(32'h100, 32'h100, 32'h1000_0001, 1'b0, 1);
        read_op(32'h24, 32'h28, 32'h2424_2424, 1'b0, 2);   // address changed mid-fetch
        read_op(32'h24, 32'h24, 32'h2424_2424, 1'b1, 0);
        read_op(32'h28, 32'h28, 32'h2828_2828, 1'b0, 1);

`ifdef SA_CACHE_STATS_EN
        want_h = 32'(exp_hits);
        want_m = 32'(exp_misses);
`else
        want_h = 32'd0;
        want_m = 32'd0;
`endif
        #1;
        chk("stat_hits",   bus.stat_hits,   want_h);
        chk("stat_misses", bus.stat_misses, want_m);

        // Stray ack while idle is ignored.
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #1;
        chk("idle_ack_ready", 32'(bus.cpu_ready), 32'd0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        chk("idle_ack_memreq", 32'(bus.mem_req), 32'd0);

        // Reset flushes the cache; reset mid-fetch abandons the transaction.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst2_shits", bus.stat_hits,   32'd0);
        chk("rst2_smiss", bus.stat_misses, 32'd0);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h40;
        #1;
        chk("abort_miss", 32'(bus.miss), 32'd1);
        @(negedge clk);
        #1;
        chk("abort_memreq", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("abort_ready",  32'(bus.cpu_ready), 32'd0);
        chk("abort_memreq_low", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        read_op(32'h40, 32'h40, 32'h4141_4141, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
